// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   MAX_READ_PORTS / MAX_WRITE_PORTS : legal port-count limits
//   wr_prio_idx()                    : highest-index write-match select, used
//                                      by both the write and bypass paths
package regfile_pkg;

    localparam int unsigned MAX_READ_PORTS  = 4;
    localparam int unsigned MAX_WRITE_PORTS = 3;
    localparam int unsigned WP_IDX_W        = 2;

    // Returns the index of the highest set bit of the match vector.
    // The result is only meaningful when at least one bit is set.
    function automatic logic [WP_IDX_W-1:0] wr_prio_idx(input logic [MAX_WRITE_PORTS-1:0] match);
        logic [WP_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_WRITE_PORTS; i++) begin
            if (match[i]) idx = WP_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register.
//   clk, rst_n            : clock, async active-low reset
//   we_i, waddr_i         : writeback ports; a write releases its register
//   rsv_en_i, rsv_addr_i  : reserve request; marks a register busy
//   flush_i               : clears every busy bit
//   busy_o                : registered busy vector, one bit per register
// Priority per bit: flush > reserve > release > hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned COUNT       = 32,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned ZERO_REG    = 1,
    localparam int unsigned ADDR_WIDTH = $clog2(COUNT)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [WRITE_PORTS-1:0]                 we_i,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
    input  logic                                   rsv_en_i,
    input  logic [ADDR_WIDTH-1:0]                  rsv_addr_i,
    input  logic                                   flush_i,
    output logic [COUNT-1:0]                       busy_o
);

    logic [COUNT-1:0] busy_q;
    logic [COUNT-1:0] busy_d;

    // Out-of-range addresses never match any r < COUNT, so they are ignored.
    always_comb begin
        logic clr;
        logic set;
        busy_d = busy_q;
        for (int unsigned r = 0; r < COUNT; r++) begin
            clr = 1'b0;
            set = rsv_en_i && (rsv_addr_i == ADDR_WIDTH'(r));
            for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
                if (we_i[i] && (waddr_i[i] == ADDR_WIDTH'(r))) clr = 1'b1;
            end
            if (flush_i)  busy_d[r] = 1'b0;
            else if (set) busy_d[r] = 1'b1;
            else if (clr) busy_d[r] = 1'b0;
            if ((ZERO_REG != 0) && (r == 0)) busy_d[r] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-to-read
// bypass and a per-register busy scoreboard.
//   clk, rst_n : clock, async active-low reset (clears data and busy bits)
//   raddr      : READ_PORTS read addresses
//   rdata      : combinational read data
//   rbusy      : busy bit of each raddr (masked by a same-cycle write when BYPASS=1)
//   we/waddr/wdata : WRITE_PORTS write ports, highest index wins on conflict
//   rsv_en/rsv_addr: reserve a register (busy from the next cycle)
//   flush      : clear all busy bits, contents untouched
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH       = `WORD_WIDTH,
    parameter int unsigned COUNT       = 32,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned ZERO_REG    = 1,
    parameter int unsigned BYPASS      = 1,
    localparam int unsigned ADDR_WIDTH = $clog2(COUNT)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]       rdata,
    output logic [READ_PORTS-1:0]                  rbusy,
    input  logic [WRITE_PORTS-1:0]                 we,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]      wdata,
    input  logic                                   rsv_en,
    input  logic [ADDR_WIDTH-1:0]                  rsv_addr,
    input  logic                                   flush
);

    if (READ_PORTS < 1 || READ_PORTS > MAX_READ_PORTS ||
        WRITE_PORTS < 1 || WRITE_PORTS > MAX_WRITE_PORTS) begin : g_bad_ports
        $error("regfile_mp: READ_PORTS must be 1..4 and WRITE_PORTS 1..3");
    end

    logic [WIDTH-1:0] regs_q [COUNT];
    logic [WIDTH-1:0] regs_d [COUNT];
    logic [COUNT-1:0] busy;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < COUNT[ADDR_WIDTH:0];
    endfunction

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] sel_wdata(
        input logic [MAX_WRITE_PORTS-1:0]        m,
        input logic [WRITE_PORTS-1:0][WIDTH-1:0] wd
    );
        logic [WP_IDX_W-1:0] idx;
        logic [WIDTH-1:0]    v;
        idx = wr_prio_idx(m);
        v   = '0;
        for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
            if (idx == WP_IDX_W'(i)) v = wd[i];
        end
        return v;
    endfunction

    // Write path: per register, pick the highest-index port targeting it.
    always_comb begin
        logic [MAX_WRITE_PORTS-1:0] m;
        for (int unsigned r = 0; r < COUNT; r++) begin
            regs_d[r] = regs_q[r];
            m = '0;
            for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
                m[i] = we[i] && (waddr[i] == ADDR_WIDTH'(r)) && writable(waddr[i]);
            end
            if (|m) regs_d[r] = sel_wdata(m, wdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < COUNT; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .COUNT       (COUNT),
        .WRITE_PORTS (WRITE_PORTS),
        .ZERO_REG    (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we),
        .waddr_i    (waddr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush),
        .busy_o     (busy)
    );

    // Read path: a same-cycle write (BYPASS=1) overrides both data and busy.
    always_comb begin
        logic [MAX_WRITE_PORTS-1:0] m;
        logic [ADDR_WIDTH-1:0]      a;
        for (int unsigned j = 0; j < READ_PORTS; j++) begin
            a = raddr[j];
            m = '0;
            for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
                m[i] = we[i] && (waddr[i] == a) && writable(a);
            end
            if ((BYPASS != 0) && (|m)) begin
                rdata[j] = sel_wdata(m, wdata);
                rbusy[j] = 1'b0;
            end else if (in_range(a)) begin
                rdata[j] = regs_q[a];
                rbusy[j] = busy[a];
            end else begin
                rdata[j] = '0;
                rbusy[j] = 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, the next generation of the core's single-write, two-read register file.
- Adds N read ports, M write ports and an optional hardwired-zero register.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard (reserve on issue, release on writeback).
- Sits between decode/issue and the writeback stage.

Parameters:
- WIDTH, `WORD_WIDTH, data bits per register
- COUNT, 32, number of registers; ADDR_WIDTH = $clog2(COUNT), localparam
- READ_PORTS, 2, number of read ports, range 1..4
- WRITE_PORTS, 2, number of write ports, range 1..3
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, 1 = reads see same-cycle writes

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- raddr  in  READ_PORTS x ADDR_WIDTH  read addresses
- rdata  out  READ_PORTS x WIDTH  read data
- rbusy  out  READ_PORTS  scoreboard busy bit of each raddr
- we  in  WRITE_PORTS  write enables
- waddr  in  WRITE_PORTS x ADDR_WIDTH  write addresses
- wdata  in  WRITE_PORTS x WIDTH  write data
- rsv_en  in  1  reserve request; marks rsv_addr busy
- rsv_addr  in  ADDR_WIDTH  register to reserve
- flush  in  1  clears all busy bits, register contents untouched

Behaviour:
- Reset (async assert, sync-released by the system):
  - All registers <= 0 and all busy bits <= 0 immediately on rst_n low.
  - Hence rdata = 0 and rbusy = 0 while in reset.
  - A reset mid-operation discards in-flight writes and reservations.
- Write:
  - On posedge clk, each port with we[i]=1 writes wdata[i] to waddr[i].
  - Write-write conflict on the same address: the highest port index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Read:
  - Combinational, zero latency.
  - BYPASS=1: if any we[i] targets raddr[j] (and it is not the zero register), rdata[j] = wdata of the highest-index matching port, else the stored value.
  - BYPASS=0: rdata[j] is always the stored value; the new value is visible the cycle after the write.
- Scoreboard, one busy bit per register:
  - Set at posedge when rsv_en=1 for rsv_addr.
  - Cleared at posedge when any we[i]=1 writes that register.
  - Same cycle, same register, reserve + write: the reserve wins, so the bit ends set (the new producer supersedes).
  - flush=1: every bit is cleared; any simultaneous rsv_en is ignored and flush wins.
  - ZERO_REG=1: the busy bit of register 0 is constant 0 and rsv to address 0 is ignored.
- rbusy:
  - BYPASS=1: rbusy[j] = busy[raddr[j]] AND NOT (a same-cycle write to raddr[j]), so a consumer can issue on the writeback cycle.
  - BYPASS=0: rbusy[j] = registered busy bit.
  - rbusy ignores same-cycle rsv_en (new reservations become visible next cycle).
- Out-of-range addresses (COUNT not a power of 2):
  - Writes are dropped, reads return 0 with rbusy=0.
  - rsv_en to such an address is ignored.
- Elaboration: assertion fails if READ_PORTS or WRITE_PORTS is out of range.

Decomposition:
- Package regfile_pkg holds:
  - Port-count limits MAX_READ_PORTS=4 and MAX_WRITE_PORTS=3.
  - A function for the highest-index write-match priority select, shared by the write and bypass paths.
- Sub-module regfile_scoreboard, parametrised on COUNT/WRITE_PORTS/ZERO_REG.
  - Contains the busy-bit vector, with reserve/release/flush priority logic.
  - Same clk/rst_n.
  - Outputs the busy vector; the top module does the per-port lookup and bypass masking.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle -> rdata for r5 reads 0 immediately; all rbusy=0.
- Write conflict: we=2'b11, waddr={7,7}, wdata={0xAAAA (port1), 0x5555 (port0)} -> next cycle r7 = 0xAAAA.
- Bypass:
  - BYPASS=1: raddr[0]=3 while port0 writes 0x1234 to r3 -> rdata[0] = 0x1234 in the same cycle.
  - BYPASS=0: rdata[0] shows the old value that cycle and 0x1234 the next.
- Zero register: write 0xFFFFFFFF to r0 and rsv_en on r0 -> rdata = 0 and rbusy = 0 forever after.
- Scoreboard:
  - rsv r9 at cycle 0 -> rbusy=1 at cycles 1..3.
  - Write r9 at cycle 4 -> rbusy=0 in cycle 4 (BYPASS=1) and 0 thereafter.
  - rsv r9 + write r9 in the same cycle -> r9 stays busy and the data is updated.
- Flush: reserve r1, r2, r3, then flush=1 together with rsv_en on r4 -> all busy bits 0 next cycle, r4 not busy, register contents unchanged.
